// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory request handshake
// and the IF/ID pipeline register. Handles variable-latency memory, hazard
// stalls (with a skid buffer for data that arrives while held) and branch /
// jump redirects, including redirects that land while a request is in flight.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        WritePC_i,
  input  logic        WriteIFID_i,
  input  logic        Flush_i,
  input  logic [31:0] Target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic        busy_o,
  output logic [31:0] IFID_pc_o,
  output logic [31:0] IFID_inst_o,
  output logic        IFID_valid_o
);

  // IDLE: not started; FETCH: request out; HOLD: acked data parked in the
  // skid buffer during a stall; DRAIN: redirect seen mid-request, waiting
  // for the stale ack before switching to the pending target.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetchState_e;

  fetchState_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] ifidPc_q, ifidPc_d;
  logic [31:0] ifidInst_q, ifidInst_d;
  logic        ifidValid_q, ifidValid_d;

  logic        stall;
  logic [31:0] pcPlus4;

  assign stall   = !WritePC_i || !WriteIFID_i;
  assign pcPlus4 = pc_q + 32'd4;

  // Request and address are pure functions of state/PC so they stay stable until ack.
  always_comb begin
    imem_req_o  = (state_q == FETCH) || (state_q == DRAIN);
    imem_addr_o = pc_q;
    busy_o      = imem_req_o && !imem_ack_i;
  end

  assign pc_o         = pc_q;
  assign IFID_pc_o    = ifidPc_q;
  assign IFID_inst_o  = ifidInst_q;
  assign IFID_valid_o = ifidValid_q;

  // Next-state logic: flush beats stall everywhere except IDLE, where both are ignored.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pending_d   = pending_q;
    skid_d      = skid_q;
    ifidPc_d    = ifidPc_q;
    ifidInst_d  = ifidInst_q;
    ifidValid_d = ifidValid_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (imem_ack_i) begin
          if (Flush_i) begin
            pc_d        = Target_i;
            ifidValid_d = 1'b0;
          end else if (!stall) begin
            ifidPc_d    = pcPlus4;
            ifidInst_d  = imem_data_i;
            ifidValid_d = 1'b1;
            pc_d        = pcPlus4;
          end else begin
            skid_d  = imem_data_i;
            state_d = HOLD;
          end
        end else begin
          if (Flush_i) begin
            pending_d   = Target_i;
            ifidValid_d = 1'b0;
            state_d     = DRAIN;
          end else if (!stall) begin
            ifidValid_d = 1'b0;
          end
        end
      end

      HOLD: begin
        if (Flush_i) begin
          pc_d        = Target_i;
          ifidValid_d = 1'b0;
          state_d     = FETCH;
        end else if (!stall) begin
          ifidPc_d    = pcPlus4;
          ifidInst_d  = skid_q;
          ifidValid_d = 1'b1;
          pc_d        = pcPlus4;
          state_d     = FETCH;
        end
      end

      DRAIN: begin
        ifidValid_d = 1'b0;
        if (imem_ack_i) begin
          pc_d    = Flush_i ? Target_i : pending_q;
          state_d = FETCH;
        end else if (Flush_i) begin
          pending_d = Target_i;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, PC and IF/ID registers; reset abandons any outstanding request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      pending_q   <= 32'd0;
      skid_q      <= 32'd0;
      ifidPc_q    <= 32'd0;
      ifidInst_q  <= 32'd0;
      ifidValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pending_q   <= pending_d;
      skid_q      <= skid_d;
      ifidPc_q    <= ifidPc_d;
      ifidInst_q  <= ifidInst_d;
      ifidValid_q <= ifidValid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage: a latency-configurable instruction
// memory model plus a scoreboard of expected IF/ID entries.
module tb_if_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        WritePC_i = 1'b1;
  logic        WriteIFID_i = 1'b1;
  logic        Flush_i = 1'b0;
  logic [31:0] Target_i = 32'd0;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] pc_o;
  logic        busy_o;
  logic [31:0] IFID_pc_o;
  logic [31:0] IFID_inst_o;
  logic        IFID_valid_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifidEntry_t;

  ifidEntry_t  sbQ[$];
  int          checks = 0;
  int          errors = 0;
  int          memLatency = 1;
  int          waitCnt = 0;
  logic        preReq;
  logic        preBusy;
  logic [31:0] preAddr;
  logic        prevValid = 1'b0;
  logic [31:0] prevPc = 32'd0;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .WritePC_i    (WritePC_i),
    .WriteIFID_i  (WriteIFID_i),
    .Flush_i      (Flush_i),
    .Target_i     (Target_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i),
    .pc_o         (pc_o),
    .busy_o       (busy_o),
    .IFID_pc_o    (IFID_pc_o),
    .IFID_inst_o  (IFID_inst_o),
    .IFID_valid_o (IFID_valid_o)
  );

  // Free-running clock, rising edge active.
  always #5 clk_i = ~clk_i;

  // Instruction word the memory model returns for a given address.
  function automatic logic [31:0] instOf(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic expectIfid(input logic [31:0] fetchPc);
    ifidEntry_t e;
    e.pc   = fetchPc + 32'd4;
    e.inst = instOf(fetchPc);
    sbQ.push_back(e);
  endtask

  // One clock cycle: drive inputs, answer as memory, capture pre-edge
  // combinational outputs, clock, then score any newly loaded IF/ID entry.
  task automatic applyStimulus(input logic st, input logic wp, input logic wi,
                               input logic fl, input logic [31:0] tgt);
    ifidEntry_t e;
    start_i     = st;
    WritePC_i   = wp;
    WriteIFID_i = wi;
    Flush_i     = fl;
    Target_i    = tgt;
    if (imem_req_o) begin
      imem_ack_i  = (waitCnt == memLatency - 1);
      imem_data_i = instOf(imem_addr_o);
    end else begin
      imem_ack_i  = 1'b0;
      imem_data_i = 32'hDEAD_BEEF;
    end
    #1;
    preReq  = imem_req_o;
    preBusy = busy_o;
    preAddr = imem_addr_o;
    @(posedge clk_i);
    if (preReq && !imem_ack_i) waitCnt++;
    else waitCnt = 0;
    #1;
    imem_ack_i = 1'b0;
    if (IFID_valid_o && (!prevValid || IFID_pc_o != prevPc)) begin
      checks++;
      assert (sbQ.size() > 0) else begin
        errors++;
        $error("[TB] FAIL sb_unexpected: observed pc %h expected no entry", IFID_pc_o);
      end
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput("sb_pc", IFID_pc_o, e.pc);
        checkOutput("sb_inst", IFID_inst_o, e.inst);
      end
    end
    prevValid = IFID_valid_o;
    prevPc    = IFID_pc_o;
  endtask

  task automatic doReset();
    rst_i       = 1'b1;
    imem_ack_i  = 1'b0;
    start_i     = 1'b0;
    Flush_i     = 1'b0;
    WritePC_i   = 1'b1;
    WriteIFID_i = 1'b1;
    waitCnt     = 0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i     = 1'b0;
    prevValid = 1'b0;
    prevPc    = 32'd0;
  endtask

  initial begin
    // Reset values, IDLE ignoring flush, then zero-wait streaming.
    doReset();
    checkOutput("rst_pc", pc_o, 32'd0);
    checkOutput("rst_req", 32'(imem_req_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_valid", 32'(IFID_valid_o), 32'd0);
    checkOutput("rst_ifid_pc", IFID_pc_o, 32'd0);
    checkOutput("rst_ifid_inst", IFID_inst_o, 32'd0);
    memLatency = 1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
    checkOutput("idle_pc", pc_o, 32'd0);
    checkOutput("idle_req", 32'(imem_req_o), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("t1_req_after_start", 32'(imem_req_o), 32'd1);
    expectIfid(32'h0);
    expectIfid(32'h4);
    expectIfid(32'h8);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      checkOutput("t1_addr", preAddr, 32'(i * 4));
      checkOutput("t1_valid", 32'(IFID_valid_o), 32'd1);
    end
    checkOutput("t1_pc", pc_o, 32'hC);
    checkOutput("t1_drained", 32'(sbQ.size()), 32'd0);

    // Three-cycle memory: address held, two bubbles.
    doReset();
    memLatency = 3;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    expectIfid(32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      checkOutput("t2_addr", preAddr, 32'd0);
      checkOutput("t2_busy", 32'(preBusy), 32'(i < 2));
      checkOutput("t2_valid", 32'(IFID_valid_o), 32'(i == 2));
    end
    checkOutput("t2_drained", 32'(sbQ.size()), 32'd0);

    // Stall while the ack for 0x8 arrives, then release without refetch.
    doReset();
    memLatency = 1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    expectIfid(32'h0);
    expectIfid(32'h4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("t3_stall_addr", preAddr, 32'h8);
    checkOutput("t3_hold_pc", pc_o, 32'h8);
    checkOutput("t3_hold_req", 32'(imem_req_o), 32'd0);
    checkOutput("t3_hold_ifid_pc", IFID_pc_o, 32'h8);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("t3_hold2_pc", pc_o, 32'h8);
    checkOutput("t3_hold2_ifid_inst", IFID_inst_o, instOf(32'h4));
    expectIfid(32'h8);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("t3_no_refetch", 32'(preReq), 32'd0);
    checkOutput("t3_release_pc", pc_o, 32'hC);
    checkOutput("t3_release_req", 32'(imem_req_o), 32'd1);
    checkOutput("t3_drained", 32'(sbQ.size()), 32'd0);

    // Zero-wait flush, flush beating stall, and PC wraparound.
    doReset();
    memLatency = 1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      expectIfid(32'(i * 4));
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
    checkOutput("t4_flush_addr", preAddr, 32'h10);
    checkOutput("t4_bubble", 32'(IFID_valid_o), 32'd0);
    checkOutput("t4_redirect_pc", pc_o, 32'h40);
    expectIfid(32'h40);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("t4_target_addr", preAddr, 32'h40);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
    checkOutput("t4_fs_addr", preAddr, 32'h44);
    checkOutput("t4_fs_pc", pc_o, 32'h100);
    checkOutput("t4_fs_req", 32'(imem_req_o), 32'd1);
    checkOutput("t4_fs_valid", 32'(IFID_valid_o), 32'd0);
    expectIfid(32'h100);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("t4_fs_next_addr", preAddr, 32'h100);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    expectIfid(32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("t4_wrap_addr", preAddr, 32'hFFFF_FFFC);
    checkOutput("t4_wrap_pc", pc_o, 32'd0);
    checkOutput("t4_drained", 32'(sbQ.size()), 32'd0);

    // Flush on the first cycle of a three-cycle fetch of 0x20 (DRAIN).
    doReset();
    memLatency = 1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h20);
    memLatency = 3;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h80);
    checkOutput("t5_addr1", preAddr, 32'h20);
    checkOutput("t5_busy1", 32'(preBusy), 32'd1);
    checkOutput("t5_valid1", 32'(IFID_valid_o), 32'd0);
    checkOutput("t5_req_held", 32'(imem_req_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("t5_addr2", preAddr, 32'h20);
    checkOutput("t5_valid2", 32'(IFID_valid_o), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("t5_addr3", preAddr, 32'h20);
    checkOutput("t5_busy3", 32'(preBusy), 32'd0);
    checkOutput("t5_valid3", 32'(IFID_valid_o), 32'd0);
    checkOutput("t5_pc", pc_o, 32'h80);
    expectIfid(32'h80);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      checkOutput("t5_next_addr", preAddr, 32'h80);
    end
    checkOutput("t5_drained", 32'(sbQ.size()), 32'd0);

    // Asynchronous reset in the middle of DRAIN; restart needs start_i.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    checkOutput("t6_drain_pc", pc_o, 32'h84);
    #3;
    rst_i      = 1'b1;
    imem_ack_i = 1'b0;
    #1;
    checkOutput("t6_rst_pc", pc_o, 32'd0);
    checkOutput("t6_rst_req", 32'(imem_req_o), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy_o), 32'd0);
    checkOutput("t6_rst_valid", 32'(IFID_valid_o), 32'd0);
    checkOutput("t6_rst_ifid_pc", IFID_pc_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i     = 1'b0;
    waitCnt   = 0;
    prevValid = 1'b0;
    prevPc    = 32'd0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      checkOutput("t6_idle_req", 32'(imem_req_o), 32'd0);
      checkOutput("t6_idle_pc", pc_o, 32'd0);
    end
    memLatency = 1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    expectIfid(32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("t6_resume_addr", preAddr, 32'd0);
    checkOutput("t6_drained", 32'(sbQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
